// File: rtl/instr_sequencer_if.sv
// Signal bundle between the instruction sequencer, its host loader and the downstream controller.
// master = host/controller side, slave = sequencer side.
interface instr_sequencer_if #(
   parameter int IW = 16,
   parameter int AW = 4
);
   logic          LoadEn;
   logic [AW-1:0] LoadAddr;
   logic [IW-1:0] LoadData;
   logic [AW:0]   Len;
   logic          Go;
   logic          Ready;
   logic          Start;
   logic [IW-1:0] Instr;
   logic [AW-1:0] PC;
   logic [AW:0]   Count;
   logic          Busy;
   logic          Done;
   logic          Halted;
   logic          Err;

   modport master (
      output LoadEn, LoadAddr, LoadData, Len, Go, Ready,
      input  Start, Instr, PC, Count, Busy, Done, Halted, Err
   );

   modport slave (
      input  LoadEn, LoadAddr, LoadData, Len, Go, Ready,
      output Start, Instr, PC, Count, Busy, Done, Halted, Err
   );
endinterface

// File: rtl/instr_sequencer.sv
// Issues a host-loaded program one instruction at a time to the Start/Ready controller.
// Start is registered and high for the whole ISSUE cycle; the next issue waits for Ready to rise again.
module instr_sequencer #(
   parameter int         IW      = 16,
   parameter int         AW      = 4,
   parameter int         TIMEOUT = 8,
   parameter logic [3:0] HALT_OP = 4'hF
) (
   input  logic             CLK,
   input  logic             RST,
   instr_sequencer_if.slave sif
);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_END
   } state_t;

   state_t        state_q, state_d;
   logic          start_q, start_d;
   logic [IW-1:0] instr_q, instr_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW:0]   count_q, count_d;
   logic [AW:0]   len_q, len_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          halted_q, halted_d;
   logic          err_q, err_d;
   logic          mem_we;
   logic [IW-1:0] mem_q [2**AW];
   logic [AW-1:0] pc_nxt;
   logic          last_instr;

   assign pc_nxt     = pc_q + AW'(1);
   assign last_instr = ({1'b0, pc_q} == len_q - (AW+1)'(1));

   always_ff @(posedge CLK) begin
      if (mem_we) mem_q[sif.LoadAddr] <= sif.LoadData;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_IDLE;
         start_q  <= 1'b0;
         instr_q  <= '0;
         pc_q     <= '0;
         count_q  <= '0;
         len_q    <= '0;
         timer_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         halted_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         start_q  <= start_d;
         instr_q  <= instr_d;
         pc_q     <= pc_d;
         count_q  <= count_d;
         len_q    <= len_d;
         timer_q  <= timer_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         halted_q <= halted_d;
         err_q    <= err_d;
      end
   end

   // Start is decided on entry to ISSUE so it is registered yet coincides with the ISSUE cycle.
   always_comb begin
      state_d  = state_q;
      start_d  = 1'b0;
      instr_d  = instr_q;
      pc_d     = pc_q;
      count_d  = count_q;
      len_d    = len_q;
      timer_d  = timer_q;
      busy_d   = busy_q;
      done_d   = done_q;
      halted_d = halted_q;
      err_d    = err_q;
      mem_we   = 1'b0;
      unique case (state_q)
         S_IDLE, S_END: begin
            if (sif.Go) begin
               done_d   = 1'b0;
               halted_d = 1'b0;
               err_d    = 1'b0;
               count_d  = '0;
               len_d    = sif.Len;
               if (sif.Len == '0) begin
                  done_d  = 1'b1;
                  state_d = S_END;
               end else begin
                  pc_d    = '0;
                  instr_d = mem_q[0];
                  start_d = (mem_q[0][IW-1 -: 4] != HALT_OP);
                  busy_d  = 1'b1;
                  state_d = S_ISSUE;
               end
            end else if (sif.LoadEn) begin
               mem_we = 1'b1;
            end
         end
         S_ISSUE: begin
            if (instr_q[IW-1 -: 4] == HALT_OP) begin
               halted_d = 1'b1;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = S_END;
            end else begin
               timer_d = '0;
               state_d = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (!sif.Ready) begin
               state_d = S_WAIT_DONE;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = S_END;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_WAIT_DONE: begin
            if (sif.Ready) begin
               count_d = count_q + (AW+1)'(1);
               if (last_instr) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_END;
               end else begin
                  pc_d    = pc_nxt;
                  instr_d = mem_q[pc_nxt];
                  start_d = (mem_q[pc_nxt][IW-1 -: 4] != HALT_OP);
                  state_d = S_ISSUE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign sif.Start  = start_q;
   assign sif.Instr  = instr_q;
   assign sif.PC     = pc_q;
   assign sif.Count  = count_q;
   assign sif.Busy   = busy_q;
   assign sif.Done   = done_q;
   assign sif.Halted = halted_q;
   assign sif.Err    = err_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: behavioural controller, program-level reference model, directed and random runs.
module tb_instr_sequencer;
   localparam int IW      = 16;
   localparam int AW      = 4;
   localparam int TIMEOUT = 8;
   localparam int DEPTH   = 1 << AW;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   instr_sequencer_if #(.IW(IW), .AW(AW)) sif();

   instr_sequencer #(.IW(IW), .AW(AW), .TIMEOUT(TIMEOUT), .HALT_OP(4'hF)) dut (
      .CLK(CLK),
      .RST(RST),
      .sif(sif)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [IW-1:0] tmem [DEPTH];
   logic [IW-1:0] obs [$];
   int            start_cnt = 0;
   int            wen_cnt   = 0;
   int            cyc       = 0;
   int            start_cyc = 0;
   int            err_lat   = -1;
   int            busy_cnt  = 0;
   bit            ctrl_dead = 1'b0;
   bit            ctrl_slow = 1'b0;
   bit            start_prev = 1'b0;
   bit            err_prev   = 1'b0;
   bit            wen        = 1'b0;
   logic [IW-1:0] pend_instr = '0;
   logic [AW-1:0] pend_pc    = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Controller stand-in: drops Ready after seeing Start, pulses Wen as Ready returns.
   initial begin
      sif.Ready = 1'b1;
      forever begin
         @(negedge CLK);
         cyc++;
         wen = 1'b0;
         if (RST) begin
            sif.Ready = 1'b1;
            busy_cnt  = 0;
         end else begin
            if (sif.Start) begin
               chk("start_one_cycle", {31'b0, start_prev}, 0);
               start_cnt++;
               obs.push_back(sif.Instr);
               pend_instr = sif.Instr;
               pend_pc    = sif.PC;
               start_cyc  = cyc;
            end
            if (sif.Err && !err_prev) err_lat = cyc - start_cyc;
            if (ctrl_dead) begin
               sif.Ready = 1'b1;
            end else if (sif.Ready && sif.Start) begin
               sif.Ready = 1'b0;
               busy_cnt  = ctrl_slow ? 5 : int'($urandom_range(2, 5));
            end else if (!sif.Ready) begin
               if (busy_cnt <= 1) begin
                  wen = 1'b1;
                  sif.Ready = 1'b1;
                  wen_cnt++;
                  chk("instr_stable", sif.Instr, pend_instr);
                  chk("pc_stable", sif.PC, pend_pc);
               end else begin
                  busy_cnt--;
               end
            end
         end
         start_prev = sif.Start;
         err_prev   = sif.Err;
      end
   end

   task automatic load(input int a, input logic [IW-1:0] d);
      @(negedge CLK);
      sif.LoadEn   = 1'b1;
      sif.LoadAddr = a[AW-1:0];
      sif.LoadData = d;
      tmem[a]      = d;
      @(negedge CLK);
      sif.LoadEn   = 1'b0;
   endtask

   task automatic run(input int len, input bit dead, input bit disturb, input bit go_load);
      logic [IW-1:0] exp_issue [$];
      int exp_cnt  = 0;
      int exp_pc   = 0;
      bit exp_halt = 1'b0;
      bit exp_err  = 1'b0;
      bit exp_done = 1'b0;
      int k;

      // Program-level expectation: walk the program until length, halt or a dead controller.
      if (len == 0) exp_done = 1'b1;
      for (int i = 0; i < len; i++) begin
         exp_pc = i;
         if (tmem[i][IW-1 -: 4] == 4'hF) begin
            exp_halt = 1'b1;
            exp_done = 1'b1;
            break;
         end
         exp_issue.push_back(tmem[i]);
         if (dead) begin
            exp_err = 1'b1;
            break;
         end
         exp_cnt++;
         if (i == len - 1) exp_done = 1'b1;
      end

      obs.delete();
      start_cnt = 0;
      wen_cnt   = 0;
      err_lat   = -1;
      ctrl_dead = dead;
      @(negedge CLK);
      sif.Len = len[AW:0];
      sif.Go  = 1'b1;
      if (go_load) begin
         sif.LoadEn   = 1'b1;
         sif.LoadAddr = '0;
         sif.LoadData = ~tmem[0];
      end
      @(negedge CLK);
      sif.Go     = 1'b0;
      sif.LoadEn = 1'b0;
      if (len == 0) chk("done_after_go_len0", {31'b0, sif.Done}, 1);
      else          chk("busy_after_go", {31'b0, sif.Busy}, 1);
      if (disturb) begin
         repeat (2) @(negedge CLK);
         sif.LoadEn   = 1'b1;
         sif.LoadAddr = AW'(1);
         sif.LoadData = 16'hFFFF;
         sif.Go       = 1'b1;
         @(negedge CLK);
         sif.LoadEn = 1'b0;
         sif.Go     = 1'b0;
      end
      for (k = 0; k < 400 && sif.Busy; k++) @(negedge CLK);
      if (k == 400) chk("run_timeout", 1, 0);
      @(negedge CLK);
      ctrl_dead = 1'b0;

      chk("n_start", start_cnt, exp_issue.size());
      for (int i = 0; i < exp_issue.size() && i < obs.size(); i++)
         chk("issued_instr", obs[i], exp_issue[i]);
      chk("n_wen", wen_cnt, exp_cnt);
      chk("count", sif.Count, exp_cnt);
      chk("done", {31'b0, sif.Done}, {31'b0, exp_done});
      chk("halted", {31'b0, sif.Halted}, {31'b0, exp_halt});
      chk("err", {31'b0, sif.Err}, {31'b0, exp_err});
      chk("busy_end", {31'b0, sif.Busy}, 0);
      if (len != 0) begin
         chk("pc", sif.PC, exp_pc);
         chk("instr_end", sif.Instr, tmem[exp_pc]);
      end
      if (exp_err) chk("err_latency", err_lat, TIMEOUT + 1);
   endtask

   initial begin
      logic [IW-1:0] d;
      int k;
      RST          = 1'b1;
      sif.LoadEn   = 1'b0;
      sif.LoadAddr = '0;
      sif.LoadData = '0;
      sif.Len      = '0;
      sif.Go       = 1'b0;
      for (int i = 0; i < DEPTH; i++) tmem[i] = '0;
      repeat (3) @(negedge CLK);
      chk("rst_start", {31'b0, sif.Start}, 0);
      chk("rst_instr", sif.Instr, 0);
      chk("rst_pc", sif.PC, 0);
      chk("rst_count", sif.Count, 0);
      chk("rst_busy", {31'b0, sif.Busy}, 0);
      chk("rst_done", {31'b0, sif.Done}, 0);
      chk("rst_halted", {31'b0, sif.Halted}, 0);
      chk("rst_err", {31'b0, sif.Err}, 0);
      RST = 1'b0;
      // Memory is not reset: give every word a defined value first.
      for (int i = 0; i < DEPTH; i++) load(i, 16'h0000);

      load(0, 16'h1234); load(1, 16'h0001); load(2, 16'h0AB0);
      run(3, 1'b0, 1'b0, 1'b0);

      load(0, 16'h0001); load(1, 16'hF000);
      run(4, 1'b0, 1'b0, 1'b0);

      run(0, 1'b0, 1'b0, 1'b0);

      load(0, 16'h1234); load(1, 16'h0001);
      run(2, 1'b1, 1'b0, 1'b0);

      load(2, 16'h0AB0);
      run(3, 1'b0, 1'b1, 1'b0);
      run(3, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < DEPTH; i++) begin
         d = IW'($urandom) & 16'h7FFF;
         load(i, d);
      end
      run(16, 1'b0, 1'b0, 1'b0);

      // Reset while the controller is still writing back.
      load(0, 16'h1234); load(1, 16'h0001); load(2, 16'h0AB0);
      ctrl_slow = 1'b1;
      @(negedge CLK);
      sif.Len = 5'd3;
      sif.Go  = 1'b1;
      @(negedge CLK);
      sif.Go = 1'b0;
      for (k = 0; k < 50 && sif.Ready; k++) @(negedge CLK);
      if (k == 50) chk("ready_fall_timeout", 1, 0);
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      chk("midrst_start", {31'b0, sif.Start}, 0);
      chk("midrst_instr", sif.Instr, 0);
      chk("midrst_pc", sif.PC, 0);
      chk("midrst_count", sif.Count, 0);
      chk("midrst_busy", {31'b0, sif.Busy}, 0);
      chk("midrst_done", {31'b0, sif.Done}, 0);
      chk("midrst_halted", {31'b0, sif.Halted}, 0);
      chk("midrst_err", {31'b0, sif.Err}, 0);
      @(negedge CLK);
      RST = 1'b0;
      ctrl_slow = 1'b0;
      run(1, 1'b0, 1'b0, 1'b0);

      for (int it = 0; it < 25; it++) begin
         for (int i = 0; i < DEPTH; i++) begin
            d = IW'($urandom);
            if ($urandom_range(0, 11) == 0) d[IW-1 -: 4] = 4'hF;
            else if (d[IW-1 -: 4] == 4'hF) d[IW-1 -: 4] = 4'h3;
            load(i, d);
         end
         run(int'($urandom_range(0, DEPTH)), ($urandom_range(0, 7) == 0), 1'b0,
             ($urandom_range(0, 5) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
